// File: rtl/prog_run_ctrl_pkg.sv
// Shared types for the BatPU2 program loader / run sequencer.
package batpu_ctrl_pkg;
  localparam int IADDR_W_DEF = 10;
  localparam int CYCLE_W_DEF = 24;
  localparam int IMEM_DEPTH  = 2 ** IADDR_W_DEF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_HI,
    ST_LOAD_LO,
    ST_START,
    ST_RUN
  } ctrl_state_t;

  typedef enum logic [1:0] {
    SR_NONE    = 2'd0,
    SR_HLT     = 2'd1,
    SR_TIMEOUT = 2'd2,
    SR_ABORT   = 2'd3
  } stop_reason_t;
endpackage

// File: rtl/run_budget_counter.sv
// Saturating executed-cycle counter with a look-ahead flag for the budget's final cycle.
module run_budget_counter #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic [W-1:0] count,
  output logic         last
);
  logic [W:0] cnt_inc;

  assign cnt_inc = {1'b0, count} + {{W{1'b0}}, 1'b1};
  // last means the next executed cycle is the limit-th one
  assign last    = (limit != '0) && (cnt_inc == {1'b0, limit});

  always_ff @(posedge clk) begin
    if (rst || clr)
      count <= '0;
    else if (en && (count != '1))
      count <= cnt_inc[W-1:0];
  end
endmodule

// File: rtl/prog_run_ctrl.sv
// Loads instruction memory from a byte stream, then starts and supervises the BatPU2 core.
module prog_run_ctrl
  import batpu_ctrl_pkg::*;
#(
  parameter int IADDR_W = IADDR_W_DEF,
  parameter int CYCLE_W = CYCLE_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_load,
  input  logic [IADDR_W:0]   cmd_len,
  input  logic               cmd_run,
  input  logic [CYCLE_W-1:0] cmd_limit,
  input  logic               cmd_abort,
  input  logic               rx_valid,
  input  logic [7:0]         rx_data,
  output logic               rx_ready,
  output logic               imem_we,
  output logic [IADDR_W-1:0] imem_waddr,
  output logic [15:0]        imem_wdata,
  output logic               cpu_start,
  output logic               cpu_halt,
  input  logic               cpu_hlt,
  output logic               busy,
  output logic               load_done,
  output logic               run_done,
  output logic [1:0]         stop_reason,
  output logic [CYCLE_W-1:0] cycle_count
);
  localparam logic [IADDR_W:0] DEPTH = {1'b1, {IADDR_W{1'b0}}};

  ctrl_state_t        state;
  stop_reason_t       reason_q;
  logic [IADDR_W:0]   addr_q, addr_nxt, len_q;
  logic [7:0]         hi_q;
  logic [CYCLE_W-1:0] limit_q;
  logic               cnt_clr, cnt_en, budget_last;

  assign addr_nxt    = addr_q + 1'b1;
  assign busy        = (state != ST_IDLE);
  assign rx_ready    = (state == ST_LOAD_HI) || (state == ST_LOAD_LO);
  assign cpu_start   = (state == ST_START);
  assign stop_reason = reason_q;

  // Count START plus every RUN cycle except the exit cycle, so the value held
  // during RUN cycle k is k and it freezes there when the run ends.
  assign cnt_clr = (state == ST_IDLE) && cmd_run && !cmd_load;
  assign cnt_en  = ((state == ST_START) && !cmd_abort) ||
                   ((state == ST_RUN) && !cpu_hlt && !cpu_halt && !cmd_abort);

  run_budget_counter #(.W(CYCLE_W)) u_budget (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .limit (limit_q),
    .count (cycle_count),
    .last  (budget_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      reason_q   <= SR_NONE;
      cpu_halt   <= 1'b1;
      imem_we    <= 1'b0;
      imem_waddr <= '0;
      imem_wdata <= '0;
      load_done  <= 1'b0;
      run_done   <= 1'b0;
      addr_q     <= '0;
      len_q      <= '0;
      hi_q       <= '0;
      limit_q    <= '0;
    end else begin
      imem_we   <= 1'b0;
      load_done <= 1'b0;
      run_done  <= 1'b0;
      case (state)
        ST_IDLE: begin
          cpu_halt <= 1'b1;
          if (cmd_load) begin
            if (cmd_len == '0) begin
              load_done <= 1'b1;
            end else begin
              state  <= ST_LOAD_HI;
              addr_q <= '0;
              len_q  <= (cmd_len > DEPTH) ? DEPTH : cmd_len;
            end
          end else if (cmd_run) begin
            state    <= ST_START;
            cpu_halt <= 1'b0;
            reason_q <= SR_NONE;
            limit_q  <= cmd_limit;
          end
        end
        ST_LOAD_HI: begin
          if (cmd_abort) begin
            state    <= ST_IDLE;
            reason_q <= SR_ABORT;
          end else if (rx_valid) begin
            hi_q  <= rx_data;
            state <= ST_LOAD_LO;
          end
        end
        ST_LOAD_LO: begin
          if (cmd_abort) begin
            state    <= ST_IDLE;
            reason_q <= SR_ABORT;
          end else if (rx_valid) begin
            imem_we    <= 1'b1;
            imem_waddr <= addr_q[IADDR_W-1:0];
            imem_wdata <= {hi_q, rx_data};
            addr_q     <= addr_nxt;
            if (addr_nxt == len_q) begin
              state     <= ST_IDLE;
              load_done <= 1'b1;
            end else begin
              state <= ST_LOAD_HI;
            end
          end
        end
        ST_START: begin
          if (cmd_abort) begin
            state    <= ST_IDLE;
            reason_q <= SR_ABORT;
            run_done <= 1'b1;
            cpu_halt <= 1'b1;
          end else begin
            state    <= ST_RUN;
            cpu_halt <= budget_last;
          end
        end
        ST_RUN: begin
          // cpu_halt high inside RUN marks the final budgeted cycle
          if (cpu_hlt || cpu_halt || cmd_abort) begin
            state    <= ST_IDLE;
            run_done <= 1'b1;
            cpu_halt <= 1'b1;
            reason_q <= cpu_hlt ? SR_HLT : (cpu_halt ? SR_TIMEOUT : SR_ABORT);
          end else begin
            cpu_halt <= budget_last;
          end
        end
        default: begin
          state    <= ST_IDLE;
          cpu_halt <= 1'b1;
        end
      endcase
    end
  end
endmodule
